// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller
// Owns the architectural fetch PC for the 5-stage RV32I core. Each cycle it
// picks the next PC from one of these sources: EX misprediction redirect, a
// halting ecall, a load-use stall, the IF predictor, or sequential fetch. It
// also drives the IF/ID and ID/EX write/flush controls, runs the halt-drain
// state machine, and keeps saturating flush and stall counters.

module pc_redirect_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_redirect_valid,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic             hazard_stall,
    input  logic             ecall_halt,
    output logic [31:0]      pc_out,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t      state;
    state_t      next_state;
    logic [3:0]  drain_cnt;
    logic [31:0] next_pc;
    logic        start_halt;
    logic        count_flush;
    logic        count_stall;

    // Choose the winning PC source and the pipeline controls for this cycle.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        next_pc     = pc_out + 32'd4;
        next_state  = state;
        start_halt  = 1'b0;
        count_flush = 1'b0;
        count_stall = 1'b0;
        case (state)
            RUN: begin
                if (ex_redirect_valid) begin
                    next_pc     = ex_redirect_pc;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    count_flush = 1'b1;
                end else if (ecall_halt) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    start_halt  = 1'b1;
                    next_state  = DRAIN;
                end else if (hazard_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    count_stall = 1'b1;
                end else if (pred_valid) begin
                    next_pc = pred_pc;
                end
            end
            DRAIN, HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (state == DRAIN && drain_cnt == 4'd1) begin
                    next_state = HALTED;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Halt-drain state machine; halted is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
            halted    <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == HALTED);
            if (start_halt) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 4'd1;
            end
        end
    end

    // Architectural PC register, written only when the selected source allows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= RESET_PC;
        end else if (pc_write) begin
            pc_out <= next_pc;
        end
    end

    // Performance counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (count_flush && flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_ONE;
            end
            if (count_stall && stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller
// Directed bench for the fetch PC controller: reset, sequential fetch,
// redirect/prediction priority, stalls, halt drain, wrap, saturation and
// reset during drain. Counters are 4 bits wide so saturation is reachable.

module tb_pc_redirect_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_redirect_valid;
    logic [31:0]      ex_redirect_pc;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             hazard_stall;
    logic             ecall_halt;
    logic [31:0]      pc_out;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] stall_count;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    pc_redirect_controller #(
        .RESET_PC    (32'h0000_0000),
        .DRAIN_CYCLES(4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_redirect_valid(ex_redirect_valid),
        .ex_redirect_pc   (ex_redirect_pc),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .hazard_stall     (hazard_stall),
        .ecall_halt       (ecall_halt),
        .pc_out           (pc_out),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .halted           (halted),
        .flush_count      (flush_count),
        .stall_count      (stall_count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Return every request input to idle.
    task automatic clear_inputs();
        ex_redirect_valid = 1'b0;
        ex_redirect_pc    = 32'h0;
        pred_valid        = 1'b0;
        pred_pc           = 32'h0;
        hazard_stall      = 1'b0;
        ecall_halt        = 1'b0;
    endtask

    // Advance one clock and land just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        clear_inputs();
        reset = 1'b0;
        #2;
        check_output("reset_pc", pc_out, 32'h0);
        check_output("reset_halted", {31'b0, halted}, 32'h0);
        check_output("reset_flush_count", {28'b0, flush_count}, 32'h0);
        check_output("reset_stall_count", {28'b0, stall_count}, 32'h0);
        step();
        reset = 1'b1;
        #1;

        // Sequential fetch from RESET_PC.
        check_output("seq_pc0", pc_out, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_output("seq_pc", pc_out, 32'(4 * i));
            check_output("seq_if_id_flush", {31'b0, if_id_flush}, 32'h0);
            check_output("seq_id_ex_flush", {31'b0, id_ex_flush}, 32'h0);
        end

        // Redirect beats prediction.
        pred_valid = 1'b1;
        pred_pc    = 32'h40;
        step();
        clear_inputs();
        check_output("pred_pc", pc_out, 32'h40);
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h100;
        pred_valid        = 1'b1;
        pred_pc           = 32'h80;
        #1;
        check_output("redir_if_id_flush", {31'b0, if_id_flush}, 32'h1);
        check_output("redir_id_ex_flush", {31'b0, id_ex_flush}, 32'h1);
        step();
        clear_inputs();
        check_output("redir_pc", pc_out, 32'h100);
        check_output("redir_flush_count", {28'b0, flush_count}, 32'h1);

        // Stall sequence with a competing prediction.
        pred_valid = 1'b1;
        pred_pc    = 32'h20;
        step();
        check_output("stall_start_pc", pc_out, 32'h20);
        hazard_stall = 1'b1;
        pred_pc      = 32'h90;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("stall_pc", pc_out, 32'h20);
            check_output("stall_id_ex_flush", {31'b0, id_ex_flush}, 32'h1);
            check_output("stall_if_id_write", {31'b0, if_id_write}, 32'h0);
            check_output("stall_pc_write", {31'b0, pc_write}, 32'h0);
            step();
        end
        clear_inputs();
        check_output("stall_hold_pc", pc_out, 32'h20);
        check_output("stall_count", {28'b0, stall_count}, 32'h3);
        step();
        check_output("stall_resume_pc", pc_out, 32'h24);

        // Redirect and halt together: redirect wins, no drain.
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h200;
        ecall_halt        = 1'b1;
        #1;
        check_output("rh_pc_write", {31'b0, pc_write}, 32'h1);
        check_output("rh_id_ex_flush", {31'b0, id_ex_flush}, 32'h1);
        step();
        clear_inputs();
        check_output("rh_pc", pc_out, 32'h200);
        check_output("rh_flush_count", {28'b0, flush_count}, 32'h2);
        for (int i = 1; i <= 6; i++) begin
            step();
            check_output("rh_halted", {31'b0, halted}, 32'h0);
        end
        check_output("rh_run_pc", pc_out, 32'h218);

        // Halt and stall together: halt wins, stall not counted.
        ecall_halt   = 1'b1;
        hazard_stall = 1'b1;
        #1;
        check_output("hs_if_id_write", {31'b0, if_id_write}, 32'h1);
        check_output("hs_id_ex_flush", {31'b0, id_ex_flush}, 32'h0);
        step();
        clear_inputs();
        check_output("hs_stall_count", {28'b0, stall_count}, 32'h3);

        // Fresh reset, then a full halt drain from pc 0x8.
        reset = 1'b0;
        #1;
        check_output("rst2_pc", pc_out, 32'h0);
        check_output("rst2_flush_count", {28'b0, flush_count}, 32'h0);
        reset = 1'b1;
        step();
        step();
        check_output("halt_start_pc", pc_out, 32'h8);
        ecall_halt = 1'b1;
        #1;
        check_output("halt_pc_write", {31'b0, pc_write}, 32'h0);
        check_output("halt_if_id_flush", {31'b0, if_id_flush}, 32'h1);
        check_output("halt_id_ex_flush", {31'b0, id_ex_flush}, 32'h0);
        check_output("halt_t_halted", {31'b0, halted}, 32'h0);
        step();
        clear_inputs();
        for (int k = 1; k <= 4; k++) begin
            check_output("drain_halted", {31'b0, halted}, 32'h0);
            check_output("drain_pc", pc_out, 32'h8);
            check_output("drain_id_ex_flush", {31'b0, id_ex_flush}, 32'h1);
            check_output("drain_if_id_write", {31'b0, if_id_write}, 32'h0);
            step();
        end
        check_output("halted_rise", {31'b0, halted}, 32'h1);
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'h500;
        step();
        step();
        clear_inputs();
        check_output("halted_redir_pc", pc_out, 32'h8);
        check_output("halted_flush_count", {28'b0, flush_count}, 32'h0);
        check_output("halted_sticky", {31'b0, halted}, 32'h1);

        // Reset leaves HALTED and fetch resumes.
        reset = 1'b0;
        #1;
        check_output("rst3_halted", {31'b0, halted}, 32'h0);
        reset = 1'b1;
        step();
        check_output("rst3_resume_pc", pc_out, 32'h4);

        // Reset asserted in the middle of DRAIN.
        ecall_halt = 1'b1;
        step();
        clear_inputs();
        step();
        check_output("middrain_pc_write", {31'b0, pc_write}, 32'h0);
        reset = 1'b0;
        #1;
        check_output("middrain_rst_pc", pc_out, 32'h0);
        check_output("middrain_rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b1;
        #1;
        check_output("middrain_run_pc_write", {31'b0, pc_write}, 32'h1);
        step();
        check_output("middrain_resume_pc", pc_out, 32'h4);

        // PC wraps modulo 2^32.
        ex_redirect_valid = 1'b1;
        ex_redirect_pc    = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        check_output("wrap_top_pc", pc_out, 32'hFFFF_FFFC);
        step();
        check_output("wrap_pc", pc_out, 32'h0);

        // Flush counter saturates after 20 redirects.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            ex_redirect_valid = 1'b1;
            ex_redirect_pc    = 32'h300 + 32'(4 * i);
            step();
            check_output("sat_flush_count", {28'b0, flush_count}, (i > 15) ? 32'd15 : 32'(i));
        end
        clear_inputs();
        check_output("sat_last_pc", pc_out, 32'h350);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_controller.md
# pc_redirect_controller

Sequences the fetch PC for the 5-stage pipelined RV32I core. It arbitrates every next-PC source: EX-stage misprediction redirect, halt request, load-use stall, IF-stage prediction, and sequential fetch. It owns the architectural PC register and the IF/ID and ID/EX write/flush controls. It runs a halt-drain state machine and keeps saturating flush and stall counters for performance reporting.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DRAIN_CYCLES, 4, cycles spent in DRAIN before HALTED; legal range 1..15
- CNT_W, 32, width of each performance counter

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ex_redirect_valid  in  1  EX resolved a misprediction this cycle
- ex_redirect_pc  in  32  correct target from EX
- pred_valid  in  1  IF predictor supplies a target for the current PC
- pred_pc  in  32  predicted target
- hazard_stall  in  1  ID load-use hazard
- ecall_halt  in  1  halting ecall present in ID
- pc_out  out  32  registered current fetch PC
- pc_write  out  1  PC register updates this cycle
- if_id_write  out  1  IF/ID register loads this cycle
- if_id_flush  out  1  IF/ID is replaced with a bubble
- id_ex_flush  out  1  ID/EX is replaced with a bubble
- halted  out  1  registered; core has fully drained
- flush_count  out  CNT_W  redirects accepted
- stall_count  out  CNT_W  stall cycles applied

## Operation
- States: RUN, DRAIN, HALTED. A 4-bit drain counter is used in DRAIN.
- In RUN, one source wins per cycle, in this priority order:
  1. **ex_redirect_valid:** pc <= ex_redirect_pc. if_id_flush=1, id_ex_flush=1. flush_count increments. The ecall_halt, hazard_stall and pred_valid inputs are ignored, because those instructions are on the wrong path.
  2. **ecall_halt:** pc_write=0, if_id_flush=1. The ID/EX register loads the ecall normally. State goes to DRAIN, with the drain counter loaded to DRAIN_CYCLES.
  3. **hazard_stall:** pc_write=0, if_id_write=0, id_ex_flush=1. stall_count increments.
  4. **pred_valid:** pc <= pred_pc.
  5. **otherwise:** pc <= pc_out + 4. This is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- Default outputs in RUN with no event: pc_write=1, if_id_write=1, both flush outputs 0.
- In DRAIN:
  - Outputs are pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
  - All request inputs are ignored. Only instructions older than the ecall remain in flight, and none of them can redirect.
  - The drain counter decrements each cycle. When the counter equals 1, the next state is HALTED.
- In HALTED: same outputs as DRAIN and halted=1. The state is sticky until reset.
- Counters saturate at all-ones and never wrap.
- Control outputs are combinational from state and inputs. pc_out and halted are registered.

## Timing
- Reset (asynchronous assert, takes effect immediately) forces:
  - pc_out=RESET_PC, state=RUN, drain counter=0
  - halted=0, flush_count=0, stall_count=0
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN.
- On the first rising edge after reset deasserts, pc_out becomes RESET_PC+4, provided no inputs are active.
- **Redirect:** sampled in cycle t. Flushes are asserted in cycle t, and pc_out equals ex_redirect_pc in cycle t+1. A one-cycle penalty is visible on the flush outputs only.
- **Stall:** pc_out is unchanged in cycle t+1. Consecutive stall cycles each add 1 to stall_count.
- **Halt:** sampled in cycle t. DRAIN occupies cycles t+1 .. t+DRAIN_CYCLES. halted=1 from cycle t+DRAIN_CYCLES+1 onward.
- **Simultaneous events:**
  - Redirect and halt: the redirect wins and the state stays RUN.
  - Halt and stall: the halt wins and stall_count is unchanged.
  - Stall and pred_valid: the stall wins and pc holds.
- There is no combinational path from any input to pc_out or halted.

## Test plan
- **Reset and sequential fetch:** reset low, then high with RESET_PC=0 and no inputs active. Required response: pc_out reads 0, 4, 8, 12 on consecutive cycles, and all flush outputs stay 0.
- **Redirect beats prediction:** at pc_out=0x40, drive ex_redirect_valid=1, ex_redirect_pc=0x100, pred_valid=1, pred_pc=0x80 for one cycle. Required response: if_id_flush=id_ex_flush=1 in that cycle, pc_out=0x100 in the next cycle, flush_count=1.
- **Stall sequence:** at pc_out=0x20, hold hazard_stall=1 for 3 cycles with pred_valid=1 and pred_pc=0x90. Required response: pc_out stays 0x20 for those 3 cycles, id_ex_flush=1 and if_id_write=0 each cycle, stall_count=3, then pc_out=0x24 in the next cycle once pred_valid is dropped.
- **Halt drain with DRAIN_CYCLES=4:** ecall_halt pulsed in cycle t. Required response: pc_out frozen from t onward, halted=0 through t+4 and halted=1 at t+5. A later ex_redirect_valid leaves pc_out and flush_count unchanged.
- **Redirect and halt together:** drive ex_redirect_valid=1 (ex_redirect_pc=0x200) and ecall_halt=1 in the same cycle. Required response: state stays RUN, pc_out=0x200 in the next cycle, and halted never rises.
- **Wrap, saturation and mid-drain reset:**
  - pc_out=0xFFFF_FFFC with no event: pc_out=0 in the next cycle.
  - With CNT_W=4 and 20 redirects: flush_count=15.
  - Reset asserted during DRAIN: pc_out=RESET_PC immediately, halted=0, and fetch resumes.
